// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared opcodes, ALU/immediate/writeback codes and FSM state type for the multi-cycle core
package core_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    // Arithmetic funct3 -> ALU operation; sub selects SUB over ADD for funct3 000.
    // funct3 011 (sltu) has no dedicated ALU code and shares SLT.
    function automatic logic [2:0] alu_from_funct3(input logic [2:0] funct3, input logic sub);
        case (funct3)
            3'b000:  return sub ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLT;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - unified memory port handshake between the sequencer and memory
// Signals: mem_req/mem_we/mem_addr_sel driven by the sequencer (master),
//          mem_ready returned by memory (slave) in the cycle a request completes.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
    modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/alu_dec.sv
// rtl/alu_dec.sv - combinational opcode/funct decode to ALU control plus instruction legality
// Ports: opcode, funct3, funct7 in (held IR fields); alu_ctrl out (ALU_* code);
//        legal out (1 = instruction supported by this core).
module alu_dec
    import core_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [2:0] alu_ctrl,
    output logic       legal
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b0;
        case (opcode)
            OP_R: begin
                // Only base encodings and SUB; SRA and M-extension encodings trap.
                legal    = (funct7 == 7'b0000000) ||
                           ((funct7 == 7'b0100000) && (funct3 == 3'b000));
                alu_ctrl = alu_from_funct3(funct3, funct7[5]);
            end
            OP_IALU: begin
                // No SUBI exists, so funct7 never selects subtraction here.
                legal    = 1'b1;
                alu_ctrl = alu_from_funct3(funct3, 1'b0);
            end
            OP_LW, OP_SW: begin
                legal    = 1'b1;
                alu_ctrl = ALU_ADD;
            end
            OP_BR: begin
                legal    = (funct3 == 3'b000) || (funct3 == 3'b001);
                alu_ctrl = ALU_SUB;
            end
            OP_JAL, OP_LUI: begin
                legal    = 1'b1;
                alu_ctrl = ALU_ADD;
            end
            default: begin
                legal    = 1'b0;
                alu_ctrl = ALU_ADD;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I-subset core
// Ports: clk, rst_n (sync active-low), start (leave IDLE);
//        opcode/funct3/funct7 held IR fields, branch_taken from the datapath comparator;
//        mem (master modport) unified memory handshake;
//        ir_wr_en, pc_wr_en, pc_src, wr_en_reg, wb_sel, alu_src_b, aluCTRL, immFormat datapath controls;
//        illegal (sticky trap flag), instret (retired count), state (debug).
module multicycle_ctrl
    import core_pkg::*;
#(
    parameter int unsigned INSTRET_W         = 32,
    parameter int unsigned RESET_STATE_FETCH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 branch_taken,
    multicycle_ctrl_if.master    mem,
    output logic                 ir_wr_en,
    output logic                 pc_wr_en,
    output logic                 pc_src,
    output logic                 wr_en_reg,
    output logic [1:0]           wb_sel,
    output logic                 alu_src_b,
    output logic [2:0]           aluCTRL,
    output logic [2:0]           immFormat,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret,
    output logic [2:0]           state
);

    localparam state_t RESET_STATE = (RESET_STATE_FETCH != 0) ? ST_FETCH : ST_IDLE;
    localparam logic [INSTRET_W-1:0] INSTRET_ONE = 1;

    state_t                 state_q;
    state_t                 state_d;
    logic [INSTRET_W-1:0]   instret_q;
    logic                   retire;
    logic [2:0]             dec_alu;
    logic                   dec_legal;
    logic [2:0]             imm_fmt;

    logic is_r, is_i, is_lw, is_sw, is_br, is_jal, is_lui;

    assign is_r   = (opcode == OP_R);
    assign is_i   = (opcode == OP_IALU);
    assign is_lw  = (opcode == OP_LW);
    assign is_sw  = (opcode == OP_SW);
    assign is_br  = (opcode == OP_BR);
    assign is_jal = (opcode == OP_JAL);
    assign is_lui = (opcode == OP_LUI);

    alu_dec u_alu_dec (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7   (funct7),
        .alu_ctrl (dec_alu),
        .legal    (dec_legal)
    );

    always_comb begin
        imm_fmt = IMM_I;
        if (is_sw) begin
            imm_fmt = IMM_S;
        end else if (is_br) begin
            imm_fmt = IMM_B;
        end else if (is_lui) begin
            imm_fmt = IMM_U;
        end else if (is_jal) begin
            imm_fmt = IMM_J;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RESET_STATE;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                instret_q <= instret_q + INSTRET_ONE;
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        retire           = 1'b0;
        mem.mem_req      = 1'b0;
        mem.mem_we       = 1'b0;
        mem.mem_addr_sel = 1'b0;
        ir_wr_en         = 1'b0;
        pc_wr_en         = 1'b0;
        pc_src           = 1'b0;
        wr_en_reg        = 1'b0;
        wb_sel           = WB_ALU;
        alu_src_b        = 1'b0;
        aluCTRL          = ALU_ADD;
        immFormat        = IMM_I;

        // ALU op and immediate format stay valid from EXEC until the instruction retires,
        // so MEM address and WB result remain stable while memory stalls.
        if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
            aluCTRL   = dec_alu;
            immFormat = imm_fmt;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ready) begin
                    ir_wr_en = 1'b1;
                    pc_wr_en = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = dec_legal ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                if (is_r || is_i) begin
                    alu_src_b = is_i;
                    state_d   = ST_WB;
                end else if (is_lw || is_sw) begin
                    alu_src_b = 1'b1;
                    state_d   = ST_MEM;
                end else if (is_br) begin
                    // funct3[0] distinguishes BNE (take when not equal) from BEQ.
                    pc_wr_en = 1'b1;
                    pc_src   = funct3[0] ? ~branch_taken : branch_taken;
                    retire   = 1'b1;
                    state_d  = ST_FETCH;
                end else if (is_jal) begin
                    wr_en_reg = 1'b1;
                    wb_sel    = WB_PC;
                    pc_wr_en  = 1'b1;
                    pc_src    = 1'b1;
                    retire    = 1'b1;
                    state_d   = ST_FETCH;
                end else if (is_lui) begin
                    state_d = ST_WB;
                end else begin
                    // Unreachable after DECODE screening; fail safe if IR changes under us.
                    state_d = ST_TRAP;
                end
            end
            ST_MEM: begin
                mem.mem_req      = 1'b1;
                mem.mem_addr_sel = 1'b1;
                mem.mem_we       = is_sw;
                alu_src_b        = 1'b1;
                if (mem.mem_ready) begin
                    if (is_sw) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                wr_en_reg = 1'b1;
                alu_src_b = is_i;
                wb_sel    = is_lw ? WB_MEM : (is_lui ? WB_IMM : WB_ALU);
                retire    = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase

        // While reset is asserted every strobe is quiet, which also drops any
        // request left outstanding by the state being reset.
        if (!rst_n) begin
            retire           = 1'b0;
            mem.mem_req      = 1'b0;
            mem.mem_we       = 1'b0;
            mem.mem_addr_sel = 1'b0;
            ir_wr_en         = 1'b0;
            pc_wr_en         = 1'b0;
            pc_src           = 1'b0;
            wr_en_reg        = 1'b0;
            wb_sel           = WB_ALU;
            alu_src_b        = 1'b0;
            aluCTRL          = ALU_ADD;
            immFormat        = IMM_I;
        end
    end

    // TRAP is absorbing, so the flag is sticky until reset.
    assign illegal = rst_n && (state_q == ST_TRAP);
    assign instret = instret_q;
    assign state   = state_q;

endmodule
